pipe_stage_reg: RTL and testbench

- Generic parametrised inter-stage pipeline register for the MIPS core. It supersedes the fixed per-stage registers (D/E/M/W).
- Carries PC, IR, N payload lanes, exception code and delay-slot flag.
- Adds a valid/ready handshake, stall hold, bubble insertion, exception-code merge, flush with PC injection, and a saturating stall counter.
- Instantiated between every pair of stages; CP0 drives flush on exception/eret.

---
 rtl/pipe_stage_reg.sv | 174 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Generic inter-stage pipeline register for the MIPS core. Carries PC, IR,
//   LANES payload lanes, a merged exception code and the delay-slot flag
//   between two stages, with a valid/ready handshake and CP0 flush.
//
//   Optional feature macro: PIPE_SKID_EN
//     defined   : one-entry skid buffer; in_ready is registered (~skid_valid)
//     undefined : no skid storage; in_ready = ~out_valid | out_ready
//
//   Ports
//     clk, reset      clock, synchronous active-high reset
//     flush, flush_pc CP0 flush request and PC injected into out_pc
//     in_*            upstream handshake and instruction fields
//     stage_exc       exception raised by the upstream stage logic
//     out_*           registered instruction fields and downstream handshake
//     out_has_exc     out_valid & (out_exc != 0)
//     stall_cnt       saturating count of stalled cycles
module pipe_stage_reg #(
  parameter int unsigned           DATA_W   = 32,
  parameter int unsigned           LANES    = 4,
  parameter int unsigned           PC_W     = 32,
  parameter int unsigned           EXC_W    = 5,
  parameter logic [PC_W-1:0]       RESET_PC = PC_W'(32'h0000_3004),
  parameter int unsigned           CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [PC_W-1:0]          flush_pc,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [31:0]              in_ir,
  input  logic [LANES*DATA_W-1:0]  in_lanes,
  input  logic [EXC_W-1:0]         in_exc,
  input  logic [EXC_W-1:0]         stage_exc,
  input  logic                     in_bd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [31:0]              out_ir,
  output logic [LANES*DATA_W-1:0]  out_lanes,
  output logic [EXC_W-1:0]         out_exc,
  output logic                     out_bd,
  output logic                     out_has_exc,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int unsigned BUS_W = LANES * DATA_W;

  // Earliest exception wins: a code already in flight beats a new one.
  logic [EXC_W-1:0] merged_exc;
  assign merged_exc = (in_exc != '0) ? in_exc : stage_exc;

  logic out_free;
  assign out_free = ~out_valid | out_ready;

  logic             load_en;
  logic             bubble_en;
  logic [PC_W-1:0]  src_pc;
  logic [31:0]      src_ir;
  logic [BUS_W-1:0] src_lanes;
  logic [EXC_W-1:0] src_exc;
  logic             src_bd;

`ifdef PIPE_SKID_EN
  logic             skid_valid;
  logic [PC_W-1:0]  skid_pc;
  logic [31:0]      skid_ir;
  logic [BUS_W-1:0] skid_lanes;
  logic [EXC_W-1:0] skid_exc;
  logic             skid_bd;
  logic             skid_fill;

  assign in_ready = ~skid_valid;

  // A parked entry always drains before new input; in_ready is low while
  // the skid is full, so no input can compete with it.
  assign skid_fill = in_valid & ~skid_valid & ~out_free;

  always_comb begin
    load_en   = out_free & (skid_valid | in_valid);
    bubble_en = out_free & ~skid_valid & ~in_valid;
    if (skid_valid) begin
      src_pc    = skid_pc;
      src_ir    = skid_ir;
      src_lanes = skid_lanes;
      src_exc   = skid_exc;
      src_bd    = skid_bd;
    end else begin
      src_pc    = in_pc;
      src_ir    = in_ir;
      src_lanes = in_lanes;
      src_exc   = merged_exc;
      src_bd    = in_bd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_ir    <= '0;
      skid_lanes <= '0;
      skid_exc   <= '0;
      skid_bd    <= 1'b0;
    end else if (skid_fill) begin
      skid_valid <= 1'b1;
      skid_pc    <= in_pc;
      skid_ir    <= in_ir;
      skid_lanes <= in_lanes;
      skid_exc   <= merged_exc;
      skid_bd    <= in_bd;
    end else if (out_free) begin
      skid_valid <= 1'b0;
    end
  end
`else
  assign in_ready = out_free;

  always_comb begin
    load_en   = out_free & in_valid;
    bubble_en = out_free & ~in_valid;
    src_pc    = in_pc;
    src_ir    = in_ir;
    src_lanes = in_lanes;
    src_exc   = merged_exc;
    src_bd    = in_bd;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_pc    <= RESET_PC;
      out_ir    <= '0;
      out_lanes <= '0;
      out_exc   <= '0;
      out_bd    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_pc    <= flush_pc;
      out_ir    <= '0;
      out_lanes <= '0;
      out_exc   <= '0;
      out_bd    <= 1'b0;
    end else if (load_en) begin
      out_valid <= 1'b1;
      out_pc    <= src_pc;
      out_ir    <= src_ir;
      out_lanes <= src_lanes;
      out_exc   <= src_exc;
      out_bd    <= src_bd;
    end else if (bubble_en) begin
      // out_pc is kept so the EPC source stays defined across bubbles.
      out_valid <= 1'b0;
      out_ir    <= '0;
      out_lanes <= '0;
      out_exc   <= '0;
      out_bd    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign out_has_exc = out_valid & (out_exc != '0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int unsigned CNT_W_TB = 4;
  localparam logic [31:0] RST_PC   = 32'h0000_3004;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic         clk, reset, flush, in_valid, in_ready, in_bd;
  logic         out_valid, out_ready, out_bd, out_has_exc;
  logic [31:0]  flush_pc, in_pc, in_ir, out_pc, out_ir;
  logic [127:0] in_lanes, out_lanes;
  logic [4:0]   in_exc, stage_exc, out_exc;
  logic [CNT_W_TB-1:0] stall_cnt;

  pipe_stage_reg #(
    .DATA_W(32), .LANES(4), .PC_W(32), .EXC_W(5),
    .RESET_PC(RST_PC), .CNT_W(CNT_W_TB)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ir(in_ir),
    .in_lanes(in_lanes), .in_exc(in_exc), .stage_exc(stage_exc), .in_bd(in_bd),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_ir(out_ir), .out_lanes(out_lanes), .out_exc(out_exc), .out_bd(out_bd),
    .out_has_exc(out_has_exc), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the stage is a FIFO of capacity CAP whose head is the
  // visible output; an empty FIFO shows the PC of the last departed entry.
  typedef struct packed {
    logic [31:0]  pc;
    logic [31:0]  ir;
    logic [127:0] lanes;
    logic [4:0]   exc;
    logic         bd;
  } entry_t;

  entry_t              q[$];
  logic [31:0]         m_last_pc = RST_PC;
  logic [CNT_W_TB-1:0] m_cnt = '0;

  function automatic logic m_in_ready();
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  function automatic entry_t m_head();
    entry_t e;
    e = '0;
    if (q.size() > 0) e = q[0];
    else e.pc = m_last_pc;
    return e;
  endfunction

  task automatic tick();
    entry_t e;
    logic rdy;
    rdy = m_in_ready();
    if (reset) begin
      q.delete(); m_last_pc = RST_PC; m_cnt = '0;
    end else if (flush) begin
      q.delete(); m_last_pc = flush_pc;
    end else begin
      if (q.size() > 0 && !out_ready && m_cnt != '1) m_cnt = m_cnt + 1'b1;
      if (q.size() > 0 && out_ready) begin
        m_last_pc = q[0].pc;
        void'(q.pop_front());
      end
      if (in_valid && rdy) begin
        e.pc = in_pc; e.ir = in_ir; e.lanes = in_lanes; e.bd = in_bd;
        e.exc = (in_exc != 0) ? in_exc : stage_exc;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                          input logic [127:0] ln, input logic [4:0] ex, input logic [4:0] sx);
    in_valid = v; in_pc = pc; in_ir = ir; in_lanes = ln;
    in_exc = ex; stage_exc = sx; in_bd = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive_in(1'b0, '0, '0, '0, '0, '0);
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    checks++; if (out_pc !== 32'h3004) begin errors++; $display("FAIL rst_pc got %h exp 00003004", out_pc); end
    checks++; if (out_ir !== 32'h0 || out_lanes !== '0 || out_exc !== 5'd0 || out_bd !== 1'b0) begin
      errors++; $display("FAIL rst_fields got ir %h exc %h bd %b exp zeros", out_ir, out_exc, out_bd); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_load();
    do_reset();
    out_ready = 1'b1;
    drive_in(1'b1, 32'h3000, 32'h2401_0005, {32'd1, 32'd2, 32'd3, 32'd4}, 5'd0, 5'd0);
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL load_valid got %b exp 1", out_valid); end
    checks++; if (out_pc !== 32'h3000) begin errors++; $display("FAIL load_pc got %h exp 00003000", out_pc); end
    checks++; if (out_ir !== 32'h2401_0005) begin errors++; $display("FAIL load_ir got %h exp 24010005", out_ir); end
    checks++; if (out_lanes !== {32'd1, 32'd2, 32'd3, 32'd4}) begin errors++; $display("FAIL load_lanes got %h", out_lanes); end
    checks++; if (out_exc !== 5'd0 || out_has_exc !== 1'b0) begin
      errors++; $display("FAIL load_exc got %0d/%b exp 0/0", out_exc, out_has_exc); end
  endtask

  task automatic test_hold();
    do_reset();
    out_ready = 1'b1;
    drive_in(1'b1, 32'h3000, 32'h2401_0005, {32'd1, 32'd2, 32'd3, 32'd4}, 5'd0, 5'd0);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_in(1'b1, 32'h5000 + 32'(i * 4), 32'hdead_0000 + 32'(i), '1, 5'd3, 5'd7);
      tick();
    end
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3000 || out_ir !== 32'h2401_0005) begin
      errors++; $display("FAIL hold_frozen got v %b pc %h ir %h exp 1 00003000 24010005", out_valid, out_pc, out_ir); end
    checks++; if (out_lanes !== {32'd1, 32'd2, 32'd3, 32'd4} || out_exc !== 5'd0) begin
      errors++; $display("FAIL hold_fields got lanes %h exc %0d", out_lanes, out_exc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready got %b exp 0", in_ready); end
    checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL hold_cnt got %0d exp 3", stall_cnt); end
  endtask

  task automatic test_exc_merge();
    do_reset();
    out_ready = 1'b1;
    drive_in(1'b1, 32'h3010, 32'h1, '0, 5'd0, 5'd12);
    tick();
    checks++; if (out_exc !== 5'd12 || out_has_exc !== 1'b1) begin
      errors++; $display("FAIL exc_stage got %0d/%b exp 12/1", out_exc, out_has_exc); end
    drive_in(1'b1, 32'h3014, 32'h2, '0, 5'd4, 5'd12);
    tick();
    checks++; if (out_exc !== 5'd4 || out_has_exc !== 1'b1) begin
      errors++; $display("FAIL exc_earliest got %0d/%b exp 4/1", out_exc, out_has_exc); end
  endtask

  task automatic test_flush_stall();
    do_reset();
    out_ready = 1'b1;
    drive_in(1'b1, 32'h3000, 32'h2401_0005, '1, 5'd6, 5'd0);
    tick();
    out_ready = 1'b0;
    tick();
    flush = 1'b1; flush_pc = 32'h4180;
    drive_in(1'b1, 32'h3020, 32'h7, '1, 5'd2, 5'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_ir !== 32'h0 || out_exc !== 5'd0 || out_lanes !== '0) begin
      errors++; $display("FAIL flush_clear got v %b ir %h exc %0d exp 0 0 0", out_valid, out_ir, out_exc); end
    checks++; if (out_pc !== 32'h4180) begin errors++; $display("FAIL flush_pc got %h exp 00004180", out_pc); end
    checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL flush_cnt got %0d exp 1", stall_cnt); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_skid_leak got %b exp 0", out_valid); end
  endtask

  task automatic test_bubble();
    do_reset();
    out_ready = 1'b1;
    drive_in(1'b1, 32'h3008, 32'hAB, '1, 5'd0, 5'd0);
    tick();
    drive_in(1'b0, 32'h9999, 32'hCD, '1, 5'd1, 5'd1);
    tick();
    checks++; if (out_valid !== 1'b0 || out_ir !== 32'h0 || out_lanes !== '0) begin
      errors++; $display("FAIL bubble_clear got v %b ir %h exp 0 0", out_valid, out_ir); end
    checks++; if (out_pc !== 32'h3008) begin errors++; $display("FAIL bubble_pc got %h exp 00003008", out_pc); end
  endtask

  // A, B, C streamed against out_ready = 1,0,1,1,1...; upstream honours in_ready.
  task automatic test_back_to_back();
    logic [31:0] seen[$];
    int idx = 0, low = 0, cyc = 0;
    do_reset();
    while (seen.size() < 3 && cyc < 20) begin
      out_ready = (cyc == 1) ? 1'b0 : 1'b1;
      if (idx < 3) drive_in(1'b1, 32'h3000 + 32'(idx * 4), 32'hA0 + 32'(idx), '0, 5'd0, 5'd0);
      else in_valid = 1'b0;
      #1;
      if (in_valid && !in_ready) low++;
      if (out_valid && out_ready) seen.push_back(out_pc);
      if (in_valid && in_ready) idx++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (seen.size() != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", seen.size()); end
    for (int i = 0; i < 3 && i < seen.size(); i++) begin
      checks++; if (seen[i] !== 32'h3000 + 32'(i * 4)) begin
        errors++; $display("FAIL b2b_order[%0d] got %h exp %h", i, seen[i], 32'h3000 + 32'(i * 4)); end
    end
    checks++; if (low != 1) begin errors++; $display("FAIL b2b_in_ready_low got %0d exp 1", low); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_dup got %b exp 0", out_valid); end
  endtask

  task automatic test_saturate();
    do_reset();
    out_ready = 1'b1;
    drive_in(1'b1, 32'h3000, 32'h1, '0, 5'd0, 5'd0);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_reach got %0d exp 15", stall_cnt); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold got %0d exp 15", stall_cnt); end
  endtask

  task automatic test_random();
    entry_t e;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      flush_pc  = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_pc     = $urandom; in_ir = $urandom;
      in_lanes  = {$urandom, $urandom, $urandom, $urandom};
      in_exc    = $urandom_range(0, 1) ? 5'($urandom) : 5'd0;
      stage_exc = $urandom_range(0, 1) ? 5'($urandom) : 5'd0;
      in_bd     = 1'($urandom);
      #1;
      checks++; if (in_ready !== m_in_ready()) begin
        errors++; $display("FAIL rnd_in_ready cyc %0d got %b exp %b", i, in_ready, m_in_ready()); end
      tick();
      e = m_head();
      checks++; if (out_valid !== (q.size() > 0)) begin
        errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, out_valid, q.size() > 0); end
      checks++; if (out_pc !== e.pc || out_ir !== e.ir || out_bd !== e.bd) begin
        errors++; $display("FAIL rnd_pc_ir cyc %0d got %h %h %b exp %h %h %b", i, out_pc, out_ir, out_bd, e.pc, e.ir, e.bd); end
      checks++; if (out_lanes !== e.lanes) begin
        errors++; $display("FAIL rnd_lanes cyc %0d got %h exp %h", i, out_lanes, e.lanes); end
      checks++; if (out_exc !== e.exc || out_has_exc !== ((q.size() > 0) && e.exc != 0)) begin
        errors++; $display("FAIL rnd_exc cyc %0d got %0d/%b exp %0d", i, out_exc, out_has_exc, e.exc); end
      checks++; if (stall_cnt !== m_cnt) begin
        errors++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", i, stall_cnt, m_cnt); end
    end
    reset = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; flush_pc = '0; out_ready = 1'b0;
    drive_in(1'b0, '0, '0, '0, '0, '0);
    test_reset();
    test_load();
    test_hold();
    test_exc_merge();
    test_flush_stall();
    test_bubble();
    test_back_to_back();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
